// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
//   Decodes a 32-bit MIPS instruction in ID into its full control word and
//   registers it into the ID/EX pipeline slot behind a valid/ready handshake.
//   A down-counter tracks multi-cycle HI/LO producers (MULT/DIV) and holds
//   back HI/LO-dependent instructions until the producer latency has elapsed.
//
// Parameters
//   DIV_CYCLES  cycles DIV/DIVU occupy HI/LO (>= 1)
//   MUL_CYCLES  cycles MULT/MULTU occupy HI/LO (0 = no stall)
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   instr_d, valid_d         ID-stage instruction and its valid flag
//   ready_d                  stage accepts instr_d this cycle (combinational)
//   valid_e, ready_e         EX slot occupancy / EX consumes the slot
//   flush_e                  kill the EX slot and abort HI/LO tracking
//   instr_e                  registered instruction
//   regwrite_e .. invalid_e  registered control word
//   hilo_busy                HI/LO producer still in flight
module decode_ctrl_pipe #(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  output logic        ready_d,
  output logic        valid_e,
  input  logic        ready_e,
  input  logic        flush_e,
  output logic [31:0] instr_e,
  output logic        regwrite_e,
  output logic        regdst_e,
  output logic        alusrc_e,
  output logic        branch_e,
  output logic        memwrite_e,
  output logic        jump_e,
  output logic        hilowrite_e,
  output logic [1:0]  memtoreg_e,
  output logic        cp0write_e,
  output logic        eret_e,
  output logic        invalid_e,
  output logic        hilo_busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes
  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_JALR    = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_BREAK   = 6'h0D;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MTHI    = 6'h11;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MTLO    = 6'h13;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1A;
  localparam logic [5:0] F_DIVU    = 6'h1B;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;
  localparam logic [5:0] F_ERET    = 6'h18;

  // REGIMM rt codes
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // COP0 rs codes
  localparam logic [4:0] RS_MFC0 = 5'h00;
  localparam logic [4:0] RS_MTC0 = 5'h04;
  localparam logic [4:0] RS_CO   = 5'h10;

  // Write-back source select
  localparam logic [1:0] MR_ALU = 2'b00;
  localparam logic [1:0] MR_MEM = 2'b01;
  localparam logic [1:0] MR_HI  = 2'b10;
  localparam logic [1:0] MR_LO  = 2'b11;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       memwrite;
    logic       jump;
    logic       hilowrite;
    logic [1:0] memtoreg;
    logic       cp0write;
    logic       eret;
    logic       invalid;
  } ctrl_t;

  localparam ctrl_t CTRL_ZERO = ctrl_t'(12'h000);

  logic [5:0]       op_s;
  logic [5:0]       funct_s;
  logic [4:0]       rs_s;
  logic [4:0]       rt_s;
  ctrl_t            dec_s;
  logic             is_hilo_s;
  logic             is_div_s;
  logic             is_mul_s;
  logic             hazard_s;
  logic             fire_s;
  ctrl_t            ctrl_r;
  logic [CNT_W-1:0] cnt_r;

  assign op_s    = instr_d[31:26];
  assign rs_s    = instr_d[25:21];
  assign rt_s    = instr_d[20:16];
  assign funct_s = instr_d[5:0];

  // Main decoder: anything not recognised yields only the invalid flag.
  always_comb begin
    dec_s     = CTRL_ZERO;
    is_hilo_s = 1'b0;
    is_div_s  = 1'b0;
    is_mul_s  = 1'b0;
    case (op_s)
      OP_SPECIAL: begin
        case (funct_s)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
          F_XOR, F_NOR, F_SLT, F_SLTU: begin
            dec_s.regwrite = 1'b1;
            dec_s.regdst   = 1'b1;
          end
          F_MULT, F_MULTU: begin
            dec_s.hilowrite = 1'b1;
            is_hilo_s       = 1'b1;
            is_mul_s        = 1'b1;
          end
          F_DIV, F_DIVU: begin
            dec_s.hilowrite = 1'b1;
            is_hilo_s       = 1'b1;
            is_div_s        = 1'b1;
          end
          F_MFHI: begin
            dec_s.regwrite = 1'b1;
            dec_s.regdst   = 1'b1;
            dec_s.memtoreg = MR_HI;
            is_hilo_s      = 1'b1;
          end
          F_MFLO: begin
            dec_s.regwrite = 1'b1;
            dec_s.regdst   = 1'b1;
            dec_s.memtoreg = MR_LO;
            is_hilo_s      = 1'b1;
          end
          F_MTHI, F_MTLO: begin
            dec_s.hilowrite = 1'b1;
            is_hilo_s       = 1'b1;
          end
          F_JR: begin
            dec_s.jump = 1'b1;
          end
          F_JALR: begin
            dec_s.jump     = 1'b1;
            dec_s.regwrite = 1'b1;
            dec_s.regdst   = 1'b1;
          end
          F_SYSCALL, F_BREAK: begin
            dec_s = CTRL_ZERO;
          end
          default: begin
            dec_s.invalid = 1'b1;
          end
        endcase
      end
      OP_REGIMM: begin
        case (rt_s)
          RT_BLTZ, RT_BGEZ: begin
            dec_s.branch = 1'b1;
          end
          RT_BLTZAL, RT_BGEZAL: begin
            dec_s.branch   = 1'b1;
            dec_s.regwrite = 1'b1;
          end
          default: begin
            dec_s.invalid = 1'b1;
          end
        endcase
      end
      OP_J: begin
        dec_s.jump = 1'b1;
      end
      OP_JAL: begin
        dec_s.jump     = 1'b1;
        dec_s.regwrite = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        dec_s.branch = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec_s.regwrite = 1'b1;
        dec_s.alusrc   = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        dec_s.regwrite = 1'b1;
        dec_s.alusrc   = 1'b1;
        dec_s.memtoreg = MR_MEM;
      end
      OP_SB, OP_SH, OP_SW: begin
        dec_s.memwrite = 1'b1;
        dec_s.alusrc   = 1'b1;
      end
      OP_COP0: begin
        case (rs_s)
          RS_MFC0: begin
            dec_s.regwrite = 1'b1;
          end
          RS_MTC0: begin
            dec_s.cp0write = 1'b1;
          end
          RS_CO: begin
            if (funct_s == F_ERET) begin
              dec_s.eret = 1'b1;
            end else begin
              dec_s.invalid = 1'b1;
            end
          end
          default: begin
            dec_s.invalid = 1'b1;
          end
        endcase
      end
      default: begin
        dec_s.invalid = 1'b1;
      end
    endcase
    // Ensure the reserved-instruction path never leaks any side effects.
    if (dec_s.invalid) begin
      dec_s.memtoreg = MR_ALU;
    end else begin
      dec_s.memtoreg = dec_s.memtoreg;
    end
  end

  // Handshake: only HI/LO-class instructions wait on the producer counter.
  assign hilo_busy = (cnt_r != CNT_ZERO);
  assign hazard_s  = hilo_busy & is_hilo_s;
  assign ready_d   = ~flush_e & ~hazard_s & (~valid_e | ready_e);
  assign fire_s    = valid_d & ready_d;

  // ID/EX slot: flush beats load, load beats drain, otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_e <= 1'b0;
      instr_e <= 32'h0000_0000;
      ctrl_r  <= CTRL_ZERO;
    end else if (flush_e) begin
      valid_e <= 1'b0;
      instr_e <= instr_e;
      ctrl_r  <= CTRL_ZERO;
    end else if (fire_s) begin
      valid_e <= 1'b1;
      instr_e <= instr_d;
      ctrl_r  <= dec_s;
    end else if (ready_e) begin
      valid_e <= 1'b0;
      instr_e <= instr_e;
      ctrl_r  <= ctrl_r;
    end else begin
      valid_e <= valid_e;
      instr_e <= instr_e;
      ctrl_r  <= ctrl_r;
    end
  end

  // HI/LO occupancy counter; keeps counting down even under back-pressure.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= CNT_ZERO;
    end else if (flush_e) begin
      cnt_r <= CNT_ZERO;
    end else if (fire_s && is_div_s) begin
      cnt_r <= DIV_LOAD;
    end else if (fire_s && is_mul_s) begin
      cnt_r <= MUL_LOAD;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= CNT_ZERO;
    end
  end

  assign regwrite_e  = ctrl_r.regwrite;
  assign regdst_e    = ctrl_r.regdst;
  assign alusrc_e    = ctrl_r.alusrc;
  assign branch_e    = ctrl_r.branch;
  assign memwrite_e  = ctrl_r.memwrite;
  assign jump_e      = ctrl_r.jump;
  assign hilowrite_e = ctrl_r.hilowrite;
  assign memtoreg_e  = ctrl_r.memtoreg;
  assign cp0write_e  = ctrl_r.cp0write;
  assign eret_e      = ctrl_r.eret;
  assign invalid_e   = ctrl_r.invalid;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Testbench for decode_ctrl_pipe. Two instances share all inputs:
//   u0: DIV_CYCLES=4, MUL_CYCLES=0   u1: DIV_CYCLES=5, MUL_CYCLES=2
// A reference model (decode table + absolute-time HI/LO busy window) is
// checked every cycle; directed steps add constant-valued expectations.
module tb_decode_ctrl_pipe;

  localparam int D0 = 4;
  localparam int M0 = 0;
  localparam int D1 = 5;
  localparam int M1 = 2;

  // control vector bit positions
  localparam int B_RW = 11, B_RD = 10, B_AS = 9, B_BR = 8, B_MW = 7, B_JP = 6;
  localparam int B_HW = 5, B_MR = 3, B_CW = 2, B_ER = 1, B_INV = 0;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        ready_e;
  logic        flush_e;

  wire  [1:0]  rdy_w, ve_w, busy_w;
  wire  [31:0] ie0_w, ie1_w;
  wire  [11:0] ctl0_w, ctl1_w;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.DIV_CYCLES(D0), .MUL_CYCLES(M0)) u0 (
    .clk(clk), .resetn(resetn), .instr_d(instr_d), .valid_d(valid_d),
    .ready_d(rdy_w[0]), .valid_e(ve_w[0]), .ready_e(ready_e), .flush_e(flush_e),
    .instr_e(ie0_w), .regwrite_e(ctl0_w[B_RW]), .regdst_e(ctl0_w[B_RD]),
    .alusrc_e(ctl0_w[B_AS]), .branch_e(ctl0_w[B_BR]), .memwrite_e(ctl0_w[B_MW]),
    .jump_e(ctl0_w[B_JP]), .hilowrite_e(ctl0_w[B_HW]), .memtoreg_e(ctl0_w[4:3]),
    .cp0write_e(ctl0_w[B_CW]), .eret_e(ctl0_w[B_ER]), .invalid_e(ctl0_w[B_INV]),
    .hilo_busy(busy_w[0]));

  decode_ctrl_pipe #(.DIV_CYCLES(D1), .MUL_CYCLES(M1)) u1 (
    .clk(clk), .resetn(resetn), .instr_d(instr_d), .valid_d(valid_d),
    .ready_d(rdy_w[1]), .valid_e(ve_w[1]), .ready_e(ready_e), .flush_e(flush_e),
    .instr_e(ie1_w), .regwrite_e(ctl1_w[B_RW]), .regdst_e(ctl1_w[B_RD]),
    .alusrc_e(ctl1_w[B_AS]), .branch_e(ctl1_w[B_BR]), .memwrite_e(ctl1_w[B_MW]),
    .jump_e(ctl1_w[B_JP]), .hilowrite_e(ctl1_w[B_HW]), .memtoreg_e(ctl1_w[4:3]),
    .cp0write_e(ctl1_w[B_CW]), .eret_e(ctl1_w[B_ER]), .invalid_e(ctl1_w[B_INV]),
    .hilo_busy(busy_w[1]));

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          busy_end [2];
  logic        m_v [2];
  logic [31:0] m_ins [2];
  logic [11:0] m_ctl [2];
  logic        last_rdy0;

  localparam logic [31:0] I_LW    = 32'h8C220004;
  localparam logic [31:0] I_DIV   = 32'h0043001A;
  localparam logic [31:0] I_MFLO  = 32'h00004012;
  localparam logic [31:0] I_MFHI  = 32'h00004010;
  localparam logic [31:0] I_ADDU  = 32'h00431021;
  localparam logic [31:0] I_ADDIU = 32'h24010001;
  localparam logic [31:0] I_ORI   = 32'h34020002;
  localparam logic [31:0] I_MULT  = 32'h00430018;
  localparam logic [31:0] I_ERET  = 32'h42000018;
  localparam logic [31:0] I_MTC0  = 32'h40816000;

  logic [31:0] pool [25] = '{
    32'h00431021, 32'h00021080, 32'h03E00008, 32'h0040F809, 32'h0000000C,
    32'h00430018, 32'h00430019, 32'h0043001A, 32'h0043001B, 32'h00004010,
    32'h00004012, 32'h00400011, 32'h00400013, 32'h10430004, 32'h04500004,
    32'h04410004, 32'h08000010, 32'h0C000010, 32'h3C011234, 32'hAC220004,
    32'h90220004, 32'h40026000, 32'h40816000, 32'h42000018, 32'hFC000000};

  // Reference decode written straight from the instruction table.
  function automatic logic [11:0] ref_decode(input logic [31:0] ins);
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    logic [11:0] c;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16];
    c = 12'h000;
    if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B}) begin
        c[B_RW] = 1'b1; c[B_RD] = 1'b1;
      end else if (fn inside {[6'h18:6'h1B], 6'h11, 6'h13}) c[B_HW] = 1'b1;
      else if (fn == 6'h10) begin c[B_RW] = 1'b1; c[B_RD] = 1'b1; c[B_MR +: 2] = 2'b10; end
      else if (fn == 6'h12) begin c[B_RW] = 1'b1; c[B_RD] = 1'b1; c[B_MR +: 2] = 2'b11; end
      else if (fn == 6'h08) c[B_JP] = 1'b1;
      else if (fn == 6'h09) begin c[B_JP] = 1'b1; c[B_RW] = 1'b1; c[B_RD] = 1'b1; end
      else if (fn inside {6'h0C, 6'h0D}) c = 12'h000;
      else c[B_INV] = 1'b1;
    end else if (op == 6'h01) begin
      if (rt inside {5'h00, 5'h01}) c[B_BR] = 1'b1;
      else if (rt inside {5'h10, 5'h11}) begin c[B_BR] = 1'b1; c[B_RW] = 1'b1; end
      else c[B_INV] = 1'b1;
    end else if (op == 6'h02) c[B_JP] = 1'b1;
    else if (op == 6'h03) begin c[B_JP] = 1'b1; c[B_RW] = 1'b1; end
    else if (op inside {[6'h04:6'h07]}) c[B_BR] = 1'b1;
    else if (op inside {[6'h08:6'h0F]}) begin c[B_RW] = 1'b1; c[B_AS] = 1'b1; end
    else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      c[B_RW] = 1'b1; c[B_AS] = 1'b1; c[B_MR +: 2] = 2'b01;
    end else if (op inside {6'h28, 6'h29, 6'h2B}) begin c[B_MW] = 1'b1; c[B_AS] = 1'b1; end
    else if (op == 6'h10) begin
      if (rs == 5'h00) c[B_RW] = 1'b1;
      else if (rs == 5'h04) c[B_CW] = 1'b1;
      else if (rs == 5'h10 && fn == 6'h18) c[B_ER] = 1'b1;
      else c[B_INV] = 1'b1;
    end else c[B_INV] = 1'b1;
    return c;
  endfunction

  function automatic bit is_hilo(input logic [31:0] ins);
    return (ins[31:26] == 6'h00) && (ins[5:0] inside {[6'h10:6'h13], [6'h18:6'h1B]});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic re, input logic fl);
    valid_d = v; instr_d = ins; ready_e = re; flush_e = fl;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0; m_ins[i] = 32'h0; m_ctl[i] = 12'h000; busy_end[i] = cyc - 1;
    end
  endtask

  // One clock cycle: check combinational outputs, advance model, check E slot.
  task automatic step();
    logic        fire [2];
    logic [11:0] d;
    int          dc, mc;
    bit          busy, rdy;
    #1;
    d = ref_decode(instr_d);
    last_rdy0 = rdy_w[0];
    for (int i = 0; i < 2; i++) begin
      busy = (cyc <= busy_end[i]);
      rdy  = !flush_e && !(busy && is_hilo(instr_d)) && (!m_v[i] || ready_e);
      check($sformatf("u%0d.ready_d@%0d", i, cyc), {31'h0, rdy_w[i]}, {31'h0, rdy});
      check($sformatf("u%0d.hilo_busy@%0d", i, cyc), {31'h0, busy_w[i]}, {31'h0, busy});
      fire[i] = valid_d && rdy;
    end
    for (int i = 0; i < 2; i++) begin
      dc = (i == 0) ? D0 : D1;
      mc = (i == 0) ? M0 : M1;
      if (flush_e) begin
        m_v[i] = 1'b0; m_ctl[i] = 12'h000; busy_end[i] = cyc;
      end else if (fire[i]) begin
        m_v[i] = 1'b1; m_ins[i] = instr_d; m_ctl[i] = d;
        if (instr_d[31:26] == 6'h00 && instr_d[5:0] inside {6'h1A, 6'h1B}) busy_end[i] = cyc + dc;
        else if (instr_d[31:26] == 6'h00 && instr_d[5:0] inside {6'h18, 6'h19}) busy_end[i] = cyc + mc;
      end else if (ready_e) begin
        m_v[i] = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check($sformatf("u0.valid_e@%0d", cyc), {31'h0, ve_w[0]}, {31'h0, m_v[0]});
    check($sformatf("u1.valid_e@%0d", cyc), {31'h0, ve_w[1]}, {31'h0, m_v[1]});
    check($sformatf("u0.ctl@%0d", cyc), {20'h0, ctl0_w}, {20'h0, m_ctl[0]});
    check($sformatf("u1.ctl@%0d", cyc), {20'h0, ctl1_w}, {20'h0, m_ctl[1]});
    if (m_v[0]) check($sformatf("u0.instr_e@%0d", cyc), ie0_w, m_ins[0]);
    if (m_v[1]) check($sformatf("u1.instr_e@%0d", cyc), ie1_w, m_ins[1]);
  endtask

  logic [31:0] bad [3] = '{32'hFC000000, 32'h04050000, 32'h42000019};

  initial begin
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_valid_e", {31'h0, ve_w[0]}, 32'h0);
    check("reset_ctl", {20'h0, ctl0_w}, 32'h0);
    check("reset_instr_e", ie0_w, 32'h0);
    check("reset_ready_d", {31'h0, rdy_w[0]}, 32'h1);
    check("reset_busy", {31'h0, busy_w[0]}, 32'h0);
    resetn = 1'b1;

    // LW into an empty slot
    drive(1'b1, I_LW, 1'b1, 1'b0); step();
    check("lw_valid", {31'h0, ve_w[0]}, 32'h1);
    check("lw_ctl", {20'h0, ctl0_w}, 32'hA08);

    // DIV then MFLO: stalled for 4 cycles, accepted in the 5th
    drive(1'b1, I_DIV, 1'b1, 1'b0); step();
    drive(1'b1, I_MFLO, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("mflo_stall_%0d", k), {31'h0, last_rdy0}, 32'h0);
    end
    step();
    check("mflo_accept", {31'h0, last_rdy0}, 32'h1);
    check("mflo_memtoreg", {30'h0, ctl0_w[4:3]}, 32'h3);
    check("mflo_instr", ie0_w, I_MFLO);

    // DIV then ADDU: no stall for non-HI/LO instruction
    drive(1'b1, I_DIV, 1'b1, 1'b0); step();
    drive(1'b1, I_ADDU, 1'b1, 1'b0); step();
    check("addu_no_stall", {31'h0, last_rdy0}, 32'h1);
    check("addu_instr", ie0_w, I_ADDU);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) step();

    // reserved encodings
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, bad[k], 1'b1, 1'b0); step();
      check($sformatf("invalid_%0d", k), {20'h0, ctl0_w}, 32'h001);
    end

    // back-pressure
    drive(1'b1, I_ADDIU, 1'b1, 1'b0); step();
    drive(1'b1, I_ORI, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_ready_%0d", k), {31'h0, last_rdy0}, 32'h0);
      check($sformatf("bp_instr_%0d", k), ie0_w, I_ADDIU);
    end
    drive(1'b1, I_ORI, 1'b1, 1'b0); step();
    check("bp_release", ie0_w, I_ORI);

    // flush while cnt=3 with MFHI presented
    drive(1'b1, I_DIV, 1'b1, 1'b0); step();
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    drive(1'b1, I_MFHI, 1'b1, 1'b1); step();
    check("flush_not_accepted", {31'h0, last_rdy0}, 32'h0);
    check("flush_valid_e", {31'h0, ve_w[0]}, 32'h0);
    check("flush_busy", {31'h0, busy_w[0]}, 32'h0);
    drive(1'b1, I_MFHI, 1'b1, 1'b0); step();
    check("post_flush_mfhi", {31'h0, last_rdy0}, 32'h1);
    check("post_flush_memtoreg", {30'h0, ctl0_w[4:3]}, 32'h2);

    // MUL_CYCLES=0: MULT then MFHI back-to-back; ERET; MTC0
    drive(1'b1, I_MULT, 1'b1, 1'b0); step();
    check("mult_accept", {31'h0, last_rdy0}, 32'h1);
    drive(1'b1, I_MFHI, 1'b1, 1'b0); step();
    check("mfhi_b2b", {31'h0, last_rdy0}, 32'h1);
    check("mfhi_b2b_instr", ie0_w, I_MFHI);
    drive(1'b1, I_ERET, 1'b1, 1'b0); step();
    check("eret_ctl", {20'h0, ctl0_w}, 32'h002);
    drive(1'b1, I_MTC0, 1'b1, 1'b0); step();
    check("mtc0_ctl", {20'h0, ctl0_w}, 32'h004);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step();

    // reset in the middle of a stall
    drive(1'b1, I_DIV, 1'b1, 1'b0); step();
    drive(1'b1, I_MFHI, 1'b1, 1'b0); step();
    resetn = 1'b0;
    #1;
    check("midreset_busy", {31'h0, busy_w[0]}, 32'h0);
    check("midreset_ready", {31'h0, rdy_w[0]}, 32'h1);
    check("midreset_valid", {31'h0, ve_w[0]}, 32'h0);
    model_reset();
    #1 resetn = 1'b1;
    step();
    check("midreset_mfhi", ie0_w, I_MFHI);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 24)] : $urandom(),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 24) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered, hazard-aware successor to the combinational main decoder. It decodes a 32-bit MIPS instruction in ID into the full control word, including exception and CP0 signals, and registers it into the ID/EX pipeline slot behind a valid/ready handshake. It also tracks multi-cycle HI/LO producers (MULT/DIV) and stalls dependent HI/LO instructions until the configured latency has elapsed.

## Interface
- DIV_CYCLES, 32: cycles DIV/DIVU occupy HI/LO. Must be ≥1.
- MUL_CYCLES, 2: cycles MULT/MULTU occupy HI/LO. 0 means no stall.
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- instr_d  in  32  ID-stage instruction
- valid_d  in  1  instr_d is valid
- ready_d  out  1  stage accepts instr_d this cycle (combinational)
- valid_e  out  1  EX slot holds a valid instruction
- ready_e  in  1  EX consumes the slot this cycle
- flush_e  in  1  kill the EX slot and abort HI/LO tracking
- instr_e  out  32  registered instruction
- regwrite_e, regdst_e, alusrc_e, branch_e, memwrite_e, jump_e, hilowrite_e  out  1 each  registered controls
- memtoreg_e  out  2  00 ALU, 01 memory, 10 HI, 11 LO
- cp0write_e, eret_e, invalid_e  out  1 each  MTC0, ERET, reserved-instruction flag
- hilo_busy  out  1  HI/LO counter nonzero

## Operation
- Decode table. Unlisted bits are 0.
  - R-type ALU/shift/arith/SLT (funct AND, OR, XOR, NOR, SLL, SRL, SRA, SLLV, SRLV, SRAV, ADD, ADDU, SUB, SUBU, SLT, SLTU): regwrite=1, regdst=1.
  - MULT, MULTU, DIV, DIVU: hilowrite=1, no regwrite.
  - MFHI: regwrite=1, regdst=1, memtoreg=10.
  - MFLO: regwrite=1, regdst=1, memtoreg=11.
  - MTHI, MTLO: hilowrite=1.
  - JR: jump=1.
  - JALR: jump=1, regwrite=1, regdst=1.
  - SYSCALL, BREAK: all 0.
  - ANDI, ORI, XORI, LUI, ADDI, ADDIU, SLTI, SLTIU: regwrite=1, alusrc=1.
  - BEQ, BNE, BGTZ, BLEZ, BLTZ, BGEZ: branch=1.
  - BLTZAL, BGEZAL: branch=1, regwrite=1.
  - J: jump=1. JAL: jump=1, regwrite=1.
  - LB, LBU, LH, LHU, LW: regwrite=1, alusrc=1, memtoreg=01.
  - SB, SH, SW: memwrite=1, alusrc=1.
  - COP0 (op 010000):
    - rs=00000 (MFC0): regwrite=1.
    - rs=00100 (MTC0): cp0write=1.
    - rs=10000 with funct 011000: eret=1.
- Any other op, funct, REGIMM rt, or COP0 rs/funct gives invalid=1 with every write-type control 0.
- HI/LO class = MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU.
- hazard = hilo_busy AND instr_d is in the HI/LO class. Non-HI/LO instructions are never blocked by the counter.
- ready_d = !flush_e AND !hazard AND (!valid_e OR ready_e).
- fire = valid_d AND ready_d.
- EX slot update, highest priority first:
  1. flush_e: valid_e←0 and all controls←0.
  2. fire: load decoded controls and instr_e, valid_e←1.
  3. ready_e: valid_e←0.
  4. Otherwise hold all E registers.
- Counter cnt, width $clog2(max(DIV_CYCLES,MUL_CYCLES)+1), priority order:
  1. flush_e: cnt←0.
  2. fire on DIV/DIVU: cnt←DIV_CYCLES.
  3. fire on MULT/MULTU: cnt←MUL_CYCLES.
  4. cnt≠0: cnt←cnt−1.
- cnt never wraps below 0.

## Timing
- Decode-to-E latency is 1 cycle. All E outputs are registered.
- ready_d and hilo_busy are combinational from state and inputs.
- Reset, asynchronous: valid_e=0, instr_e=0, all controls=0, cnt=0, hilo_busy=0.
- With valid_e=0 and flush_e=0 after reset, ready_d=1.
- Reset mid-stall clears the stall immediately.
- HI/LO producer accepted in cycle t with latency N: hilo_busy=1 in cycles t+1..t+N. A dependent HI/LO instruction is accepted no earlier than cycle t+N+1.
- Back-to-back: with ready_e held at 1, one instruction is accepted per cycle.
- Back-pressure: ready_e=0 with valid_e=1 freezes the slot and drops ready_d. The counter still decrements.
- flush_e together with valid_d: the incoming instruction is not accepted. The upstream stage must re-present it.

## Test plan
- Reset → valid_e=0, all controls 0, ready_d=1. Then LW (0x8C220004) with ready_e=1 → next cycle valid_e=1, regwrite=1, alusrc=1, memtoreg=01.
- DIV_CYCLES=4: DIV (0x0043001A) accepted cycle 0, MFLO (0x00004012) presented from cycle 1 → ready_d=0 in cycles 1–4, accepted cycle 5, memtoreg_e=11. An ADDU presented instead in cycle 1 is accepted immediately.
- Opcode 0x3F, REGIMM rt=00101, and COP0 rs=10000 with funct≠011000 → invalid_e=1, regwrite/memwrite/hilowrite/cp0write all 0.
- ready_e=0 for 3 cycles with valid_e=1 → instr_e stable, ready_d=0. Release → the queued instruction loads the next cycle.
- flush_e asserted while cnt=3 and valid_d=1 → next cycle valid_e=0, hilo_busy=0, the instruction is not accepted. The following cycle MFHI is accepted.
- MUL_CYCLES=0: MULT then MFHI back-to-back → both accepted in consecutive cycles. ERET (0x42000018) → eret_e=1. MTC0 → cp0write_e=1.
